// File: rtl/pipe_ctl_pkg.sv
// pipe_ctl_pkg: shared definitions for the stack-CPU back-end pipeline control.
//   - opcode / class constants used to decode the instruction header
//   - memin and SP-op encodings driven onto the datapath muxes
//   - ctl_t: per-instruction control bundle produced by pipe_ctl_dec
//   - stage ownership masks: which bundle fields each stage is allowed to drive
//   - ctl_of_class(): maps an instruction class to its control bundle
package pipe_ctl_pkg;

    localparam logic [3:0] OP_CALL = 4'd11;
    localparam logic [3:0] OP_RET  = 4'd10;
    localparam logic [3:0] OP_PUSH = 4'd9;
    localparam logic [1:0] T_ALU   = 2'd3;

    localparam logic [1:0] MI_REG = 2'd0;
    localparam logic [1:0] MI_PC1 = 2'd1;
    localparam logic [1:0] MI_PC  = 2'd2;

    localparam logic [1:0] SP_HOLD = 2'd0;
    localparam logic [1:0] SP_INC  = 2'd1;
    localparam logic [1:0] SP_DEC  = 2'd2;

    typedef enum logic [2:0] {
        CLS_PLAIN,
        CLS_CALL,
        CLS_RET,
        CLS_PUSH,
        CLS_STORE,
        CLS_ALU,
        CLS_ILL
    } cls_e;

    // ill and jmp are status bits rather than datapath controls: ill marks an
    // illegal encoding, jmp marks CALL/RET for the fetch hold.
    typedef struct packed {
        logic       memw;
        logic [1:0] memin;
        logic [1:0] spi;
        logic       sflag;
        logic       pcin;
        logic       pci;
        logic       regw;
        logic       ill;
        logic       jmp;
    } ctl_t;

    localparam ctl_t CTL_NONE = '0;

    // S2 owns the memory/stack controls, S3 the flag/PC controls, S4 the
    // register write. jmp is owned by both S2 and S3 so that OR-merging the
    // stages yields the fetch-hold condition directly.
    localparam ctl_t MASK_S2 = '{memw: 1'b1, memin: 2'b11, spi: 2'b11,
                                 sflag: 1'b0, pcin: 1'b0, pci: 1'b0,
                                 regw: 1'b0, ill: 1'b1, jmp: 1'b1};
    localparam ctl_t MASK_S3 = '{memw: 1'b0, memin: 2'b00, spi: 2'b00,
                                 sflag: 1'b1, pcin: 1'b1, pci: 1'b1,
                                 regw: 1'b0, ill: 1'b0, jmp: 1'b1};
    localparam ctl_t MASK_S4 = '{memw: 1'b0, memin: 2'b00, spi: 2'b00,
                                 sflag: 1'b0, pcin: 1'b0, pci: 1'b0,
                                 regw: 1'b1, ill: 1'b0, jmp: 1'b0};

    function automatic ctl_t ctl_of_class(input cls_e cls, input logic [2:0] sub);
        ctl_t c;
        c = CTL_NONE;
        case (cls)
            CLS_CALL: begin
                c.memw  = 1'b1;
                c.memin = MI_PC;
                c.spi   = SP_DEC;
                c.pcin  = 1'b1;
                c.pci   = 1'b0;
                c.jmp   = 1'b1;
            end
            CLS_RET: begin
                c.spi   = SP_INC;
                c.jmp   = 1'b1;
            end
            CLS_PUSH: begin
                c.memw  = 1'b1;
                c.memin = MI_PC1;
                c.spi   = SP_DEC;
                c.pcin  = 1'b1;
                c.pci   = 1'b1;
            end
            CLS_STORE: begin
                c.memw  = 1'b1;
                c.pcin  = 1'b1;
            end
            CLS_ALU: begin
                c.spi   = SP_INC;
                c.pcin  = 1'b1;
                c.regw  = 1'b1;
                c.sflag = (sub >= 3'd2);
            end
            CLS_ILL: begin
                c.ill   = 1'b1;
            end
            default: begin
                c.pcin  = 1'b1;
                c.pci   = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctl_dec.sv
// pipe_ctl_dec: combinational instruction decoder, one instance per stage.
//   isr  in  IW     instruction held in the stage register
//   ctl  out ctl_t  full control bundle (ungated; the caller applies valid)
// Only the header bits (opcode and ALU sub-op) carry meaning here; the
// operand bits below them are ignored.
module pipe_ctl_dec
    import pipe_ctl_pkg::*;
#(
    parameter int IW      = 16,
    parameter int ALU_OPS = 5
) (
    input  logic [IW-1:0] isr,
    output ctl_t          ctl
);

    localparam logic [2:0] SUB_MAX = 3'(ALU_OPS);

    logic [3:0] op;
    logic [1:0] t;
    logic [2:0] sub;
    cls_e       cls;
    logic       unused_isr_low;

    assign op             = isr[IW-1 -: 4];
    assign t              = isr[IW-1 -: 2];
    assign sub            = isr[IW-3 -: 3];
    assign unused_isr_low = ^isr[IW-6:0];

    always_comb begin
        cls = CLS_PLAIN;
        if (t == T_ALU) begin
            if (sub == 3'd0) begin
                cls = CLS_STORE;
            end else if (sub <= SUB_MAX) begin
                cls = CLS_ALU;
            end else begin
                cls = CLS_ILL;
            end
        end else if (op == OP_CALL) begin
            cls = CLS_CALL;
        end else if (op == OP_RET) begin
            cls = CLS_RET;
        end else if (op == OP_PUSH) begin
            cls = CLS_PUSH;
        end
    end

    always_comb begin
        ctl = ctl_of_class(cls, sub);
    end

endmodule

// File: rtl/pipe_ctl_unit.sv
// pipe_ctl_unit: back-end pipeline control for the 16-bit stack CPU.
// Registers the instruction stream through S2 (memory/stack), S3 (flag/PC)
// and S4 (writeback) with per-stage valids, stall and flush, and decodes each
// stage register into the datapath controls that stage owns.
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   isr_in     in   instruction from decode (S1)
//   isr_vld    in   isr_in valid
//   isr_rdy    out  instruction accepted this cycle when isr_vld is also high
//   stall      in   external memory stall, freezes S2..S4
//   flush      in   kills S2 and S3 at the next edge
//   memw/memin/spi   out  S2 controls
//   sflag/pcin/pci   out  S3 controls
//   regw       out  S4 control
//   ill        out  one-cycle pulse when an illegal encoding enters S2
//   stall_cnt  out  saturating count of cycles with isr_vld && !isr_rdy
module pipe_ctl_unit
    import pipe_ctl_pkg::*;
#(
    parameter int IW           = 16,
    parameter int ALU_OPS      = 5,
    parameter int HOLD_ON_JUMP = 1,
    parameter int CW           = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] isr_in,
    input  logic          isr_vld,
    output logic          isr_rdy,
    input  logic          stall,
    input  logic          flush,
    output logic          memw,
    output logic [1:0]    memin,
    output logic [1:0]    spi,
    output logic          sflag,
    output logic          pcin,
    output logic          pci,
    output logic          regw,
    output logic          ill,
    output logic [CW-1:0] stall_cnt
);

    logic [IW-1:0] s2_isr_q, s2_isr_d;
    logic [IW-1:0] s3_isr_q, s3_isr_d;
    logic [IW-1:0] s4_isr_q, s4_isr_d;
    logic          s2_vld_q, s2_vld_d;
    logic          s3_vld_q, s3_vld_d;
    logic          s4_vld_q, s4_vld_d;
    // Set only in the cycle right after an instruction is loaded into S2, so
    // ill stays a single pulse even if a stall parks the instruction there.
    logic          s2_new_q, s2_new_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    ctl_t s2_raw, s3_raw, s4_raw;
    ctl_t s2_ctl, s3_ctl, s4_ctl;
    ctl_t live;
    logic hold;
    logic accept;

    pipe_ctl_dec #(.IW(IW), .ALU_OPS(ALU_OPS)) u_dec_s2 (
        .isr (s2_isr_q),
        .ctl (s2_raw)
    );

    pipe_ctl_dec #(.IW(IW), .ALU_OPS(ALU_OPS)) u_dec_s3 (
        .isr (s3_isr_q),
        .ctl (s3_raw)
    );

    pipe_ctl_dec #(.IW(IW), .ALU_OPS(ALU_OPS)) u_dec_s4 (
        .isr (s4_isr_q),
        .ctl (s4_raw)
    );

    // Bubbles drive nothing; each stage then contributes only its own fields.
    always_comb begin
        s2_ctl = s2_vld_q ? s2_raw : CTL_NONE;
        s3_ctl = s3_vld_q ? s3_raw : CTL_NONE;
        s4_ctl = s4_vld_q ? s4_raw : CTL_NONE;
        live   = ctl_t'((s2_ctl & MASK_S2) | (s3_ctl & MASK_S3) | (s4_ctl & MASK_S4));
    end

    assign hold    = (HOLD_ON_JUMP != 0) && live.jmp;
    assign isr_rdy = !stall && !flush && !hold;
    assign accept  = isr_vld && isr_rdy;

    assign memw      = live.memw;
    assign memin     = live.memin;
    assign spi       = live.spi;
    assign sflag     = live.sflag;
    assign pcin      = live.pcin;
    assign pci       = live.pci;
    assign regw      = live.regw;
    assign ill       = live.ill && s2_new_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        s2_isr_d    = s2_isr_q;
        s3_isr_d    = s3_isr_q;
        s4_isr_d    = s4_isr_q;
        s2_vld_d    = s2_vld_q;
        s3_vld_d    = s3_vld_q;
        s4_vld_d    = s4_vld_q;
        s2_new_d    = 1'b0;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            // Flush wins over stall for S2/S3; S4 still honours the stall.
            s2_vld_d = 1'b0;
            s2_isr_d = '0;
            s3_vld_d = 1'b0;
            s3_isr_d = '0;
            if (!stall) begin
                s4_vld_d = s3_vld_q;
                s4_isr_d = s3_isr_q;
            end
        end else if (!stall) begin
            s4_vld_d = s3_vld_q;
            s4_isr_d = s3_isr_q;
            s3_vld_d = s2_vld_q;
            s3_isr_d = s2_isr_q;
            s2_vld_d = accept;
            s2_isr_d = accept ? isr_in : '0;
            s2_new_d = accept;
        end

        if (isr_vld && !isr_rdy && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_isr_q    <= '0;
            s3_isr_q    <= '0;
            s4_isr_q    <= '0;
            s2_vld_q    <= 1'b0;
            s3_vld_q    <= 1'b0;
            s4_vld_q    <= 1'b0;
            s2_new_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            s2_isr_q    <= s2_isr_d;
            s3_isr_q    <= s3_isr_d;
            s4_isr_q    <= s4_isr_d;
            s2_vld_q    <= s2_vld_d;
            s3_vld_q    <= s3_vld_d;
            s4_vld_q    <= s4_vld_d;
            s2_new_q    <= s2_new_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctl_unit.sv
// Testbench for pipe_ctl_unit: directed scenarios plus randomized traffic,
// compared every cycle against a slot-based reference model of the pipeline.
module tb_pipe_ctl_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] isr_in;
    logic        isr_vld;
    logic        stall;
    logic        flush;
    logic        isr_rdy;
    logic        memw;
    logic [1:0]  memin;
    logic [1:0]  spi;
    logic        sflag;
    logic        pcin;
    logic        pci;
    logic        regw;
    logic        ill;
    logic [7:0]  stall_cnt;

    int vectors = 0;
    int errors  = 0;

    // Reference model: three pipeline slots (0 = S2, 1 = S3, 2 = S4).
    logic        mv [3];
    logic [15:0] mi [3];
    logic        mfresh;
    int          mcnt;

    logic [15:0] pool [9] = '{16'hB000, 16'hA000, 16'h9000, 16'hC000, 16'hC800,
                              16'hD000, 16'hE000, 16'hF000, 16'hF800};

    pipe_ctl_unit #(.IW(16), .ALU_OPS(5), .HOLD_ON_JUMP(1), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .isr_in    (isr_in),
        .isr_vld   (isr_vld),
        .isr_rdy   (isr_rdy),
        .stall     (stall),
        .flush     (flush),
        .memw      (memw),
        .memin     (memin),
        .spi       (spi),
        .sflag     (sflag),
        .pcin      (pcin),
        .pci       (pci),
        .regw      (regw),
        .ill       (ill),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    wire [18:0] dut_vec = {isr_rdy, memw, memin, spi, sflag, pcin, pci, regw, ill, stall_cnt};

    // Control table by instruction class: {memw, memin, spi, sflag, pcin, pci, regw, ill}
    function automatic logic [9:0] ref_ctl(input logic [15:0] ins);
        int op;
        int sub;
        op  = int'(ins[15:12]);
        sub = int'(ins[13:11]);
        if (op == 11) return {1'b1, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        if (op == 10) return {1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        if (op == 9)  return {1'b1, 2'd1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        if (op < 12)  return {1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        if (sub == 0) return {1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        if (sub <= 5) return {1'b0, 2'd0, 2'd1, (sub >= 2), 1'b1, 1'b0, 1'b1, 1'b0};
        return 10'b00_0000_0001;
    endfunction

    function automatic logic is_jmp(input logic [15:0] ins);
        return (ins[15:12] == 4'hB) || (ins[15:12] == 4'hA);
    endfunction

    function automatic logic model_rdy();
        logic hold;
        hold = (mv[0] && is_jmp(mi[0])) || (mv[1] && is_jmp(mi[1]));
        return !stall && !flush && !hold;
    endfunction

    function automatic logic [18:0] exp_vec();
        logic [9:0] c2, c3, c4;
        c2 = mv[0] ? ref_ctl(mi[0]) : 10'd0;
        c3 = mv[1] ? ref_ctl(mi[1]) : 10'd0;
        c4 = mv[2] ? ref_ctl(mi[2]) : 10'd0;
        return {model_rdy(), c2[9], c2[8:7], c2[6:5], c3[4], c3[3], c3[2], c4[1],
                c2[0] & mfresh, 8'(mcnt)};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            mv[s] = 1'b0;
            mi[s] = 16'h0000;
        end
        mfresh = 1'b0;
        mcnt   = 0;
    endtask

    task automatic apply(input logic v, input logic [15:0] ins, input logic st, input logic fl);
        @(negedge clk);
        isr_vld = v;
        isr_in  = ins;
        stall   = st;
        flush   = fl;
        #1;
    endtask

    task automatic advance();
        logic rdy;
        logic acc;
        rdy = model_rdy();
        acc = isr_vld && rdy;
        if (isr_vld && !rdy && mcnt < 255) mcnt++;
        if (flush) begin
            if (!stall) begin
                mv[2] = mv[1];
                mi[2] = mi[1];
            end
            mv[0] = 1'b0;
            mv[1] = 1'b0;
            mfresh = 1'b0;
        end else if (!stall) begin
            mv[2] = mv[1];
            mi[2] = mi[1];
            mv[1] = mv[0];
            mi[1] = mi[0];
            mv[0] = acc;
            mi[0] = isr_in;
            mfresh = acc;
        end else begin
            mfresh = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            apply(1'b0, 16'h0000, 1'b0, 1'b0);
            advance();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        vectors++;
        if (dut_vec !== 19'h4_0000) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", dut_vec, 19'h4_0000);
        end
        rst_n = 1'b1;
        apply(1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release got %h expected %h", dut_vec, exp_vec());
        end
        advance();
    endtask

    task automatic test_alu_stream();
        logic [15:0] seq [5];
        logic        vs  [5];
        seq = '{16'hC800, 16'hD000, 16'h0000, 16'h0000, 16'h0000};
        vs  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            apply(vs[k], seq[k], 1'b0, 1'b0);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL alu_stream k=%0d got %h expected %h", k, dut_vec, exp_vec());
            end
            if (k == 1) begin
                vectors++;
                if (spi !== 2'd1) begin
                    errors++;
                    $display("FAIL alu_s2_spi got %0d expected 1", spi);
                end
            end
            if (k == 2) begin
                vectors++;
                if ({pcin, pci, sflag, spi} !== 5'b10001) begin
                    errors++;
                    $display("FAIL alu_s3 got %b expected 10001", {pcin, pci, sflag, spi});
                end
            end
            if (k == 3) begin
                vectors++;
                if ({regw, sflag} !== 2'b11) begin
                    errors++;
                    $display("FAIL alu_s4_regw_sflag got %b expected 11", {regw, sflag});
                end
            end
            advance();
        end
    endtask

    task automatic test_call_hold();
        int c0;
        int low;
        low = 0;
        idle(3);
        apply(1'b1, 16'hB000, 1'b0, 1'b0);
        vectors++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL call_issue got %h expected %h", dut_vec, exp_vec());
        end
        c0 = mcnt;
        advance();
        for (int k = 1; k <= 3; k++) begin
            apply(1'b1, 16'h9000, 1'b0, 1'b0);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL call_hold k=%0d got %h expected %h", k, dut_vec, exp_vec());
            end
            if (!isr_rdy) low++;
            if (k == 1) begin
                vectors++;
                if ({memw, memin, spi} !== 5'b11010) begin
                    errors++;
                    $display("FAIL call_s2 got %b expected 11010", {memw, memin, spi});
                end
            end
            if (k == 3) begin
                vectors++;
                if (isr_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL call_reopen got %b expected 1", isr_rdy);
                end
            end
            advance();
        end
        apply(1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++;
        if ({memw, memin} !== 3'b101) begin
            errors++;
            $display("FAIL call_next_enter got %b expected 101", {memw, memin});
        end
        vectors++;
        if (low !== 2) begin
            errors++;
            $display("FAIL call_blocked_cycles got %0d expected 2", low);
        end
        vectors++;
        if (stall_cnt !== 8'(c0 + 2)) begin
            errors++;
            $display("FAIL call_stall_cnt got %0d expected %0d", stall_cnt, c0 + 2);
        end
        advance();
    endtask

    task automatic test_stall();
        int c0;
        idle(3);
        apply(1'b1, 16'h9000, 1'b0, 1'b0);
        c0 = mcnt;
        advance();
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 16'h1234, 1'b1, 1'b0);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL stall k=%0d got %h expected %h", k, dut_vec, exp_vec());
            end
            vectors++;
            if ({memw, memin, spi, isr_rdy} !== 6'b101100) begin
                errors++;
                $display("FAIL stall_push_held k=%0d got %b expected 101100", k, {memw, memin, spi, isr_rdy});
            end
            advance();
        end
        apply(1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++;
        if (stall_cnt !== 8'(c0 + 3)) begin
            errors++;
            $display("FAIL stall_cnt got %0d expected %0d", stall_cnt, c0 + 3);
        end
        advance();
    endtask

    task automatic test_flush_stall();
        idle(3);
        apply(1'b1, 16'hC800, 1'b0, 1'b0);
        advance();
        apply(1'b1, 16'hA000, 1'b0, 1'b0);
        advance();
        apply(1'b0, 16'h0000, 1'b0, 1'b0);
        advance();
        apply(1'b0, 16'h0000, 1'b1, 1'b1);
        vectors++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL flush_setup got %h expected %h", dut_vec, exp_vec());
        end
        vectors++;
        if ({spi, pcin, regw, isr_rdy} !== 5'b00010) begin
            errors++;
            $display("FAIL flush_before got %b expected 00010", {spi, pcin, regw, isr_rdy});
        end
        advance();
        apply(1'b0, 16'h0000, 1'b1, 1'b0);
        vectors++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL flush_after got %h expected %h", dut_vec, exp_vec());
        end
        vectors++;
        if ({memw, memin, spi, sflag, pcin, pci, regw} !== 9'b000000001) begin
            errors++;
            $display("FAIL flush_outputs got %b expected 000000001", {memw, memin, spi, sflag, pcin, pci, regw});
        end
        advance();
        idle(2);
    endtask

    task automatic test_illegal();
        idle(3);
        apply(1'b1, 16'hF000, 1'b0, 1'b0);
        advance();
        for (int k = 1; k <= 3; k++) begin
            apply(1'b0, 16'h0000, 1'b0, 1'b0);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL illegal k=%0d got %h expected %h", k, dut_vec, exp_vec());
            end
            if (k == 1) begin
                vectors++;
                if ({ill, memw, spi} !== 4'b1000) begin
                    errors++;
                    $display("FAIL illegal_s2 got %b expected 1000", {ill, memw, spi});
                end
            end
            if (k == 2) begin
                vectors++;
                if ({ill, sflag, pcin, pci} !== 4'b0000) begin
                    errors++;
                    $display("FAIL illegal_s3 got %b expected 0000", {ill, sflag, pcin, pci});
                end
            end
            if (k == 3) begin
                vectors++;
                if (regw !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_s4 got %b expected 0", regw);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic        v;
        logic [15:0] ins;
        logic        st;
        logic        fl;
        for (int k = 0; k < 400; k++) begin
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) ins = 16'($urandom);
            else ins = pool[$urandom_range(0, 8)] | 16'($urandom_range(0, 2047));
            st = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 14) == 0);
            apply(v, ins, st, fl);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random k=%0d isr=%h st=%b fl=%b got %h expected %h",
                         k, ins, st, fl, dut_vec, exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 260; k++) begin
            apply(1'b1, 16'h1234, 1'b1, 1'b0);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL saturate k=%0d got %h expected %h", k, dut_vec, exp_vec());
            end
            advance();
        end
        apply(1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++;
        if (stall_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL saturate_value got %0d expected 255", stall_cnt);
        end
        advance();
    endtask

    task automatic test_reset_midstream();
        idle(3);
        apply(1'b1, 16'hC800, 1'b0, 1'b0);
        advance();
        apply(1'b1, 16'hB000, 1'b0, 1'b0);
        advance();
        @(negedge clk);
        isr_vld = 1'b0;
        isr_in  = 16'h0000;
        stall   = 1'b0;
        flush   = 1'b0;
        rst_n   = 1'b0;
        #1;
        vectors++;
        if (dut_vec !== 19'h4_0000) begin
            errors++;
            $display("FAIL reset_midstream got %h expected %h", dut_vec, 19'h4_0000);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++;
        if (stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt got %0d expected 0", stall_cnt);
        end
        vectors++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_post got %h expected %h", dut_vec, exp_vec());
        end
        advance();
    endtask

    initial begin
        rst_n   = 1'b0;
        isr_vld = 1'b0;
        isr_in  = 16'h0000;
        stall   = 1'b0;
        flush   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_alu_stream();
        test_call_hold();
        test_stall();
        test_flush_stall();
        test_illegal();
        test_random();
        test_saturate();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
